// File: rtl/core_dmem_gpio_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus a four-register
// GPIO window (DOUT, synchronised DIN, sticky change flag, free-running cycle counter).
module core_dmem_gpio_responder #(
    parameter int unsigned DEPTH      = 256,
    parameter logic [31:0] IO_BASE    = 32'h0000_0400,
    parameter logic [15:0] DOUT_RST   = 16'h0000,
    // Reset/preload value of the CYCLES counter; 0 in normal use.
    parameter logic [31:0] CYCLES_RST = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] daddr,
    input  logic [31:0] ddata_w,
    input  logic        d_rw,
    output logic [31:0] ddata_r,
    input  logic [15:0] DIN,
    output logic [15:0] DOUT,
    output logic        din_irq,
    output logic        bus_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] SEL_DOUT   = 2'd0;
    localparam logic [1:0] SEL_DIN    = 2'd1;
    localparam logic [1:0] SEL_STATUS = 2'd2;
    localparam logic [1:0] SEL_CYCLES = 2'd3;

    logic [31:0]   r_ram [DEPTH];
    logic [15:0]   r_dout;
    logic [15:0]   r_din_s1;
    logic [15:0]   r_din_s2;
    logic [15:0]   r_din_s3;
    logic          r_changed;
    logic [31:0]   r_cycles;
    logic          r_bus_err;

    logic          w_is_ram;
    logic          w_is_io;
    logic          w_unmapped;
    logic [1:0]    w_sel;
    logic [AW-1:0] w_ram_idx;
    logic          w_ram_we;
    logic          w_io_we;
    logic          w_dout_we;
    logic          w_w1c;
    logic          w_cyc_clr;
    logic          w_din_edge;
    logic [31:0]   w_rdata;

    // IO_BASE sits at or above the RAM, so the two regions never overlap.
    assign w_is_ram   = (daddr < 32'(4 * DEPTH));
    assign w_is_io    = (daddr[31:4] == IO_BASE[31:4]);
    assign w_unmapped = !w_is_ram && !w_is_io;
    assign w_sel      = daddr[3:2];
    assign w_ram_idx  = daddr[AW+1:2];

    assign w_ram_we   = d_rw && w_is_ram && !RESET;
    assign w_io_we    = d_rw && w_is_io;
    assign w_dout_we  = w_io_we && (w_sel == SEL_DOUT);
    assign w_w1c      = w_io_we && (w_sel == SEL_STATUS) && ddata_w[0];
    assign w_cyc_clr  = w_io_we && (w_sel == SEL_CYCLES);
    assign w_din_edge = (r_din_s2 != r_din_s3);

    // RAM contents survive RESET; only the write strobe is suppressed.
    always_ff @(posedge CLK) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= ddata_w;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_dout    <= DOUT_RST;
            r_din_s1  <= 16'h0000;
            r_din_s2  <= 16'h0000;
            r_din_s3  <= 16'h0000;
            r_changed <= 1'b0;
            r_cycles  <= CYCLES_RST;
            r_bus_err <= 1'b0;
        end else begin
            r_din_s1  <= DIN;
            r_din_s2  <= r_din_s1;
            r_din_s3  <= r_din_s2;
            // A new DIN edge outranks a clear landing on the same edge.
            r_changed <= w_din_edge || (r_changed && !w_w1c);
            r_cycles  <= w_cyc_clr ? 32'h0000_0000 : r_cycles + 32'd1;
            r_bus_err <= w_unmapped;
            if (w_dout_we) begin
                r_dout <= ddata_w[15:0];
            end
        end
    end

    // Read path ignores d_rw, so a read-during-write sees the pre-edge value.
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (!RESET) begin
            if (w_is_ram) begin
                w_rdata = r_ram[w_ram_idx];
            end else if (w_is_io) begin
                case (w_sel)
                    SEL_DOUT:   w_rdata = {16'h0000, r_dout};
                    SEL_DIN:    w_rdata = {16'h0000, r_din_s2};
                    SEL_STATUS: w_rdata = {31'h0, r_changed};
                    SEL_CYCLES: w_rdata = r_cycles;
                    default:    w_rdata = 32'h0000_0000;
                endcase
            end
        end
    end

    assign ddata_r = w_rdata;
    assign DOUT    = r_dout;
    assign din_irq = r_changed;
    assign bus_err = r_bus_err;

endmodule

// File: tb/tb_core_dmem_gpio_responder.sv
// Directed bench for core_dmem_gpio_responder: a behavioural model checked every
// cycle, plus hand-computed literal expectations at the interesting points.
module tb_core_dmem_gpio_responder;

    localparam logic [31:0] IO_BASE = 32'h0000_0400;
    localparam logic [31:0] A_DOUT  = IO_BASE + 32'h0;
    localparam logic [31:0] A_DIN   = IO_BASE + 32'h4;
    localparam logic [31:0] A_STAT  = IO_BASE + 32'h8;
    localparam logic [31:0] A_CYC   = IO_BASE + 32'hC;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] daddr = 32'h0;
    logic [31:0] ddata_w = 32'h0;
    logic        d_rw = 1'b0;
    logic [15:0] DIN = 16'h0;
    logic [31:0] ddata_r;
    logic [15:0] DOUT;
    logic        din_irq;
    logic        bus_err;

    logic [31:0] w_daddr = A_CYC;
    logic [31:0] w_ddata_r;
    logic [15:0] w_dout;
    logic        w_irq;
    logic        w_berr;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    core_dmem_gpio_responder dut (
        .CLK(CLK), .RESET(RESET), .daddr(daddr), .ddata_w(ddata_w), .d_rw(d_rw),
        .ddata_r(ddata_r), .DIN(DIN), .DOUT(DOUT), .din_irq(din_irq), .bus_err(bus_err)
    );

    // Second instance preloaded near the top of the counter range to reach the wrap quickly.
    core_dmem_gpio_responder #(.CYCLES_RST(32'hFFFF_FFFE)) dut_wrap (
        .CLK(CLK), .RESET(RESET), .daddr(w_daddr), .ddata_w(32'h0), .d_rw(1'b0),
        .ddata_r(w_ddata_r), .DIN(16'h0), .DOUT(w_dout), .din_irq(w_irq), .bus_err(w_berr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [int];
    logic [15:0] m_dout;
    logic [15:0] m_din [3];   // DIN as sampled 1, 2 and 3 edges ago
    logic        m_changed;
    logic [31:0] m_cycles;
    logic        m_bus_err;
    int          m_r;
    logic        m_set;
    logic [31:0] m_exp;
    int          c_r;

    // -1 unmapped, 0 RAM, 1..4 = DOUT, DIN, STATUS, CYCLES
    function automatic int region(input logic [31:0] a);
        logic [31:0] off;
        off = a - IO_BASE;
        if (a < 32'h0000_0400) return 0;
        if (off < 32'd16) return 1 + int'(off[3:2]);
        return -1;
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_dout    = 16'h0;
            m_din[0]  = 16'h0;
            m_din[1]  = 16'h0;
            m_din[2]  = 16'h0;
            m_changed = 1'b0;
            m_cycles  = 32'h0;
            m_bus_err = 1'b0;
        end else begin
            m_r   = region(daddr);
            m_set = (m_din[1] != m_din[2]);
            m_bus_err = (m_r < 0);
            m_cycles  = m_cycles + 32'd1;
            if (d_rw) begin
                if (m_r == 0) m_ram[int'(daddr >> 2)] = ddata_w;
                if (m_r == 1) m_dout = ddata_w[15:0];
                if (m_r == 3 && ddata_w[0]) m_changed = 1'b0;
                if (m_r == 4) m_cycles = 32'h0;
            end
            if (m_set) m_changed = 1'b1;
            m_din[2] = m_din[1];
            m_din[1] = m_din[0];
            m_din[0] = DIN;
        end
    end

    // Compare process: outputs settle 2 time units after each falling edge.
    always @(negedge CLK) begin
        #2;
        if (chk_en) begin
            c_r = region(daddr);
            m_exp = 32'h0;
            case (c_r)
                1: m_exp = {16'h0, m_dout};
                2: m_exp = {16'h0, m_din[1]};
                3: m_exp = {31'h0, m_changed};
                4: m_exp = m_cycles;
                default: m_exp = 32'h0;
            endcase
            if (RESET || c_r != 0) check("model_ddata_r", ddata_r, m_exp);
            else if (m_ram.exists(int'(daddr >> 2))) check("model_ram_rd", ddata_r, m_ram[int'(daddr >> 2)]);
            check("model_dout", {16'h0, DOUT}, {16'h0, m_dout});
            check("model_irq", {31'h0, din_irq}, {31'h0, m_changed});
            check("model_bus_err", {31'h0, bus_err}, {31'h0, m_bus_err});
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic rw,
                         input logic [15:0] din_v);
        @(negedge CLK);
        daddr = a; ddata_w = d; d_rw = rw; DIN = din_v;
        #3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0; daddr = A_CYC; d_rw = 1'b0; chk_en = 1'b1;
        #3;
        check("cycles_after_release", ddata_r, 32'h0);
        check("wrap_preload", w_ddata_r, 32'hFFFF_FFFE);
        drive(A_CYC, 32'h0, 1'b0, 16'h0);
        check("cycles_first_edge", ddata_r, 32'h1);
        check("wrap_max", w_ddata_r, 32'hFFFF_FFFF);
        drive(A_CYC, 32'h0, 1'b0, 16'h0);
        check("cycles_second_edge", ddata_r, 32'h2);
        check("wrap_zero", w_ddata_r, 32'h0);
        drive(A_CYC, 32'h0, 1'b0, 16'h0);
        check("wrap_one", w_ddata_r, 32'h1);

        // RAM
        drive(32'h10, 32'hDEAD_BEEF, 1'b1, 16'h0);
        drive(32'h10, 32'h0, 1'b0, 16'h0);
        check("ram_10", ddata_r, 32'hDEAD_BEEF);
        drive(32'h3FC, 32'h1234_5678, 1'b1, 16'h0);
        drive(32'h3FC, 32'h0, 1'b0, 16'h0);
        check("ram_3fc", ddata_r, 32'h1234_5678);
        drive(32'h10, 32'h1, 1'b1, 16'h0);
        check("ram_rdw_old", ddata_r, 32'hDEAD_BEEF);
        drive(32'h10, 32'h0, 1'b0, 16'h0);
        check("ram_rdw_new", ddata_r, 32'h1);

        // GPIO out
        drive(A_DOUT, 32'hABCD_5A5A, 1'b1, 16'h0);
        check("dout_before_edge", {16'h0, DOUT}, 32'h0);
        drive(A_DOUT, 32'h0, 1'b0, 16'h0);
        check("dout_after_edge", {16'h0, DOUT}, 32'h0000_5A5A);
        check("dout_read", ddata_r, 32'h0000_5A5A);

        // GPIO in: 2 edges to DIN_REG, 3 edges to din_irq
        drive(A_DIN, 32'h0, 1'b0, 16'h00F0);
        check("din_0_edges", ddata_r, 32'h0);
        drive(A_DIN, 32'h0, 1'b0, 16'h00F0);
        check("din_1_edge", ddata_r, 32'h0);
        drive(A_DIN, 32'h0, 1'b0, 16'h00F0);
        check("din_2_edges", ddata_r, 32'h0000_00F0);
        check("irq_2_edges", {31'h0, din_irq}, 32'h0);
        drive(A_DIN, 32'h0, 1'b0, 16'h00F0);
        check("irq_3_edges", {31'h0, din_irq}, 32'h1);
        drive(A_STAT, 32'h1, 1'b1, 16'h00F0);
        check("status_read", ddata_r, 32'h1);
        drive(A_STAT, 32'h0, 1'b0, 16'h00F0);
        check("irq_w1c", {31'h0, din_irq}, 32'h0);
        check("status_cleared", ddata_r, 32'h0);

        // DIN change whose set edge coincides with a W1C
        drive(A_STAT, 32'h0, 1'b0, 16'h0F0F);
        drive(A_STAT, 32'h0, 1'b0, 16'h0F0F);
        drive(A_STAT, 32'h1, 1'b1, 16'h0F0F);
        check("irq_before_set", {31'h0, din_irq}, 32'h0);
        drive(A_STAT, 32'h0, 1'b0, 16'h0F0F);
        check("irq_set_wins", {31'h0, din_irq}, 32'h1);

        // Counter clear
        drive(A_CYC, 32'hFFFF, 1'b1, 16'h0F0F);
        drive(A_CYC, 32'h0, 1'b0, 16'h0F0F);
        check("cycles_cleared", ddata_r, 32'h0);
        drive(A_CYC, 32'h0, 1'b0, 16'h0F0F);
        check("cycles_after_clear", ddata_r, 32'h1);

        // Unmapped accesses
        drive(32'h800, 32'h0, 1'b0, 16'h0F0F);
        check("unmapped_rd", ddata_r, 32'h0);
        check("berr_not_yet", {31'h0, bus_err}, 32'h0);
        drive(A_DOUT, 32'h0, 1'b0, 16'h0F0F);
        check("berr_pulse", {31'h0, bus_err}, 32'h1);
        drive(IO_BASE + 32'h14, 32'hFFFF, 1'b1, 16'h0F0F);
        check("berr_pulse_end", {31'h0, bus_err}, 32'h0);
        drive(32'h800, 32'h0, 1'b0, 16'h0F0F);
        check("berr_wr_pulse", {31'h0, bus_err}, 32'h1);
        check("unmapped_wr_no_effect", {16'h0, DOUT}, 32'h0000_5A5A);
        drive(A_DOUT, 32'h0, 1'b0, 16'h0F0F);
        check("berr_held", {31'h0, bus_err}, 32'h1);
        drive(A_DOUT, 32'h0, 1'b0, 16'h0F0F);
        check("berr_low", {31'h0, bus_err}, 32'h0);

        // Asynchronous reset in the middle of a DOUT write
        drive(32'h800, 32'h0, 1'b0, 16'h0F0F);
        drive(A_DOUT, 32'h1111, 1'b1, 16'h0F0F);
        check("pre_reset_berr", {31'h0, bus_err}, 32'h1);
        check("pre_reset_irq", {31'h0, din_irq}, 32'h1);
        RESET = 1'b1;
        #1;
        check("rst_dout", {16'h0, DOUT}, 32'h0);
        check("rst_irq", {31'h0, din_irq}, 32'h0);
        check("rst_berr", {31'h0, bus_err}, 32'h0);
        check("rst_ddata_r", ddata_r, 32'h0);
        @(negedge CLK);
        RESET = 1'b0; daddr = A_CYC; d_rw = 1'b0; ddata_w = 32'h0;
        #3;
        check("rst_cycles", ddata_r, 32'h0);
        check("rst_write_lost", {16'h0, DOUT}, 32'h0);
        drive(A_CYC, 32'h0, 1'b0, 16'h0F0F);
        check("rst_cycles_first_edge", ddata_r, 32'h1);
        drive(32'h10, 32'h0, 1'b0, 16'h0F0F);
        check("ram_retained", ddata_r, 32'h1);
        repeat (4) drive(A_STAT, 32'h0, 1'b0, 16'h0F0F);
        check("irq_after_reset_refill", {31'h0, din_irq}, 32'h1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/core_dmem_gpio_responder.md
Name: core_dmem_gpio_responder

Overview:
- Responder (slave) end of the core's data-memory port (daddr/ddata_w/ddata_r/d_rw).
- Serves a word-addressed data RAM plus a memory-mapped GPIO window that drives the 16-bit DOUT bus and samples the 16-bit DIN bus of the DUV interface.
- Sits between the single-cycle core and the system-level DIN/DOUT pins.
- Reads are combinational (same-cycle) so the single-cycle core needs no stall.

Parameters:
- DEPTH, 256, number of 32-bit RAM words (power of 2).
- IO_BASE, 32'h0000_0400, byte address of the GPIO register window (must be ≥ 4*DEPTH, 16-byte aligned).
- DOUT_RST, 16'h0000, reset value of DOUT.

Ports:
- CLK  in  1  system clock, all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- daddr  in  32  byte address from core; bits [1:0] ignored (word access only).
- ddata_w  in  32  write data from core.
- d_rw  in  1  1 = write this cycle, 0 = read.
- ddata_r  out  32  read data to core (combinational).
- DIN  in  16  asynchronous external input bus.
- DOUT  out  16  registered external output bus.
- din_irq  out  1  level = STATUS.changed.
- bus_err  out  1  one-cycle registered pulse on access to unmapped address.

Behaviour:
- Address decode (word index w = daddr[31:2]):
  - RAM: daddr < 4*DEPTH, entry daddr[log2(DEPTH)+1:2].
  - IO_BASE+0x0 DOUT_REG: RW; bits [15:0] used, reads return {16'h0, DOUT}.
  - IO_BASE+0x4 DIN_REG: RO; reads {16'h0, din_s2}; writes ignored.
  - IO_BASE+0x8 STATUS: bit0 changed (sticky); W1C via ddata_w[0]; other bits read 0.
  - IO_BASE+0xC CYCLES: RO 32-bit free-running counter; any write clears it to 0 on that edge.
  - Anything else is unmapped.
- Writes (d_rw=1) take effect on the next rising CLK edge. Reads (d_rw=0) return ddata_r combinationally from the current daddr/state.
- Read-during-write at the same address returns the old value (pre-edge).
- DIN synchronizer:
  - din_s1 <= DIN; din_s2 <= din_s1; din_s3 <= din_s2.
  - changed sets on any edge where din_s2 != din_s3.
  - DIN-to-DIN_REG latency is 2 edges; DIN-to-changed latency is 3 edges.
- Simultaneous changed-set and W1C on the same edge: set wins (changed stays 1).
- CYCLES increments by 1 every edge and wraps 0xFFFF_FFFF -> 0. A write on the same edge as the increment yields 0.
- bus_err:
  - Registered; asserted for exactly one cycle after any edge where daddr is unmapped (read or write).
  - Back-to-back unmapped accesses hold it high.
  - Unmapped reads return 32'h0; unmapped writes are discarded.
- Reset (async, mid-operation included):
  - DOUT=DOUT_RST, din_s1..s3=0, changed=0, CYCLES=0, bus_err=0, din_irq=0.
  - RAM contents are not reset (undefined after power-up, retained across RESET).
  - A write coincident with RESET assertion is lost.
- ddata_r is 32'h0 whenever RESET is high.

Test Plan:
- Reset: assert RESET mid-write to DOUT_REG -> DOUT=16'h0000, CYCLES=0, din_irq=0, bus_err=0 immediately. After release, CYCLES reads 1 on the first edge.
- RAM: write 0xDEADBEEF to 0x0000_0010, then read 0x10 -> 0xDEADBEEF. Read 0x3FC after writing 0x1234_5678 -> same. Read-during-write at 0x10 with new data 0x1 -> returns 0xDEADBEEF that cycle, 0x1 next.
- GPIO out: write 0xABCD_5A5A to IO_BASE -> DOUT=16'h5A5A after the edge. Read IO_BASE -> 0x0000_5A5A.
- GPIO in: DIN 0x0000->0x00F0 -> DIN_REG reads 0x00F0 after 2 edges, din_irq=1 after 3. Write 1 to STATUS -> din_irq=0. DIN change coinciding with W1C edge -> din_irq stays 1.
- Counter: write CYCLES -> reads 0 next cycle. Force wrap from 0xFFFF_FFFF -> 0.
- Unmapped: read 0x0000_0800 -> ddata_r=0, bus_err pulses 1 cycle. Write 0x0000_0414 -> no state change, bus_err pulse.
